riscv_alu_share_arb: RTL and testbench
======================================

// Module: riscv_alu_share_arb
//
// PURPOSE
//   Shares one riscv_alu instance between the two issue lanes of the
//   dual-issue core. Each lane presents requests over a valid/ready
//   handshake, and a round-robin arbiter grants one lane per cycle.
//   The ALU result is registered into a single-entry output stage with
//   its own valid/ready handshake, tagged with the source lane and an
//   issue tag. A saturating counter records arbitration and back-pressure
//   stalls for performance monitoring.
//
// PARAMETERS
//   TAG_W       5    width of the issue tag carried with each request (destination reg index)
//   CNT_W       16   width of the stall counter
//   FIXED_PRIO  0    0 = round-robin arbitration; 1 = lane 0 always wins a conflict
//
// PORTS
//   clk_i          in   1      core clock; all state updates on the rising edge
//   rst_i          in   1      synchronous reset, active-high
//   req0_valid_i   in   1      lane 0 request valid
//   req0_ready_o   out  1      lane 0 request accepted this cycle
//   req0_op_i      in   4      lane 0 ALU opcode (ALU_* encoding from riscv_defs.v)
//   req0_a_i       in   32     lane 0 operand A
//   req0_b_i       in   32     lane 0 operand B
//   req0_tag_i     in   TAG_W  lane 0 issue tag
//   req1_*         --   --     lane 1 request; same set and widths as req0_*
//   res_valid_o    out  1      output stage holds a valid result
//   res_ready_i    in   1      consumer accepts the result this cycle
//   res_data_o     out  32     registered ALU result
//   res_tag_o      out  TAG_W  tag of the request that produced res_data_o
//   res_src_o      out  1      source lane of the result (0 or 1)
//   stall_cnt_o    out  CNT_W  saturating count of stall cycles
//
// BEHAVIOUR
//   Reset values (synchronous, rst_i high at the clock edge):
//   - res_valid_o=0, res_data_o=0, res_tag_o=0, res_src_o=0, stall_cnt_o=0.
//   - Round-robin pointer rr_q=0, so lane 0 has priority on the first conflict.
//   - Any in-flight result is discarded, including one presented to a ready consumer in that cycle.
//   Load enable:
//   - can_load = !res_valid_o | res_ready_i.
//   Grant (combinational):
//   - Only one lane valid: that lane wins.
//   - Both lanes valid: lane rr_q wins (lane 0 if FIXED_PRIO=1).
//   - reqN_ready_o = can_load & grantN. At most one ready is high per cycle.
//   - Ready never depends on the losing lane's payload.
//   Transfer:
//   - Occurs when reqN_valid_i & reqN_ready_o.
//   - The winning lane's op/a/b are fed to the internal riscv_alu.
//   - Result, tag and lane are captured at that edge.
//   - Latency is 1 cycle: a request accepted at edge N appears on res_*_o after edge N.
//   Output stage:
//   - res_valid_o rises on a transfer.
//   - It falls on res_valid_o & res_ready_i with no new transfer.
//   - A pop and a transfer in the same cycle replace the entry with no bubble,
//     giving full throughput of 1 result/cycle.
//   - While res_valid_o & !res_ready_i, all res_*_o are held stable and both req readys stay 0.
//   Requester rules:
//   - Hold valid and payload stable until accepted; withdrawing valid is not permitted.
//   - The block does not check this rule.
//   Pointer:
//   - On every transfer, rr_q <= ~granted_lane, including uncontested grants.
//   - Otherwise rr_q is unchanged.
//   - With FIXED_PRIO=1, rr_q is ignored.
//   Stall counter:
//   - Increments by 1 in each cycle where some reqN_valid_i=1 and that lane is not accepted.
//   - Increments once per cycle even when both lanes stall.
//   - Saturates at 2^CNT_W-1 and does not wrap.
//   Arithmetic:
//   - Results match riscv_alu exactly; no width change.
//   - Unknown opcodes pass operand A through.
//
// TESTING
//   1. Reset with both lanes valid -> res_valid_o=0 and stall_cnt_o=0 during reset;
//      req0_ready_o=1 in the first cycle after reset.
//   2. Lane0 only, ADD a=7 b=5 tag=3, res_ready_i=1 -> next cycle res_valid_o=1,
//      res_data_o=12, res_tag_o=3, res_src_o=0.
//   3. Both lanes valid continuously (lane0 SUB 10-3, lane1 XOR 0xF0^0x0F),
//      res_ready_i=1 -> grants alternate 0,1,0,1.
//      Results are 7 and 0xFF alternately; stall_cnt_o increments by 1 per cycle.
//   4. res_ready_i=0 for 3 cycles with a result held -> outputs stable, both readys 0,
//      stall_cnt_o +3; raising res_ready_i pops the held result and loads the next one on the same edge.
//   5. FIXED_PRIO=1 with both lanes valid for 4 cycles -> lane 0 is granted all 4 times
//      and lane 1 stays unaccepted.
//   6. CNT_W=4, hold a stall for 20 cycles -> stall_cnt_o=15 and holds;
//      an ALU_SHIFTR_ARITH of 0x80000000 by 4 via lane1 -> res_data_o=0xF8000000.

Source files
------------

// File: rtl/riscv_alu_share_arb.sv
// One riscv_alu shared between two issue lanes: a round-robin (or fixed-priority) arbiter
// feeds a single registered result slot with valid/ready back-pressure and a stall counter.

module riscv_alu (
    input  logic [3:0]  alu_op_i,
    input  logic [31:0] alu_a_i,
    input  logic [31:0] alu_b_i,
    output logic [31:0] alu_p_o
);
    localparam logic [3:0] ALU_SHIFTL           = 4'd1;
    localparam logic [3:0] ALU_SHIFTR           = 4'd2;
    localparam logic [3:0] ALU_SHIFTR_ARITH     = 4'd3;
    localparam logic [3:0] ALU_ADD              = 4'd4;
    localparam logic [3:0] ALU_SUB              = 4'd6;
    localparam logic [3:0] ALU_AND              = 4'd7;
    localparam logic [3:0] ALU_OR               = 4'd8;
    localparam logic [3:0] ALU_XOR              = 4'd9;
    localparam logic [3:0] ALU_LESS_THAN        = 4'd10;
    localparam logic [3:0] ALU_LESS_THAN_SIGNED = 4'd11;

    // ALU_NONE and every unlisted opcode fall through to operand A
    always_comb begin
        alu_p_o = alu_a_i;
        case (alu_op_i)
            ALU_SHIFTL:           alu_p_o = alu_a_i << alu_b_i[4:0];
            ALU_SHIFTR:           alu_p_o = alu_a_i >> alu_b_i[4:0];
            ALU_SHIFTR_ARITH:     alu_p_o = 32'($signed(alu_a_i) >>> alu_b_i[4:0]);
            ALU_ADD:              alu_p_o = alu_a_i + alu_b_i;
            ALU_SUB:              alu_p_o = alu_a_i - alu_b_i;
            ALU_AND:              alu_p_o = alu_a_i & alu_b_i;
            ALU_OR:               alu_p_o = alu_a_i | alu_b_i;
            ALU_XOR:              alu_p_o = alu_a_i ^ alu_b_i;
            ALU_LESS_THAN:        alu_p_o = {31'd0, alu_a_i < alu_b_i};
            ALU_LESS_THAN_SIGNED: alu_p_o = {31'd0, $signed(alu_a_i) < $signed(alu_b_i)};
            default:              alu_p_o = alu_a_i;
        endcase
    end
endmodule

module riscv_alu_share_arb #(
    parameter int TAG_W      = 5,
    parameter int CNT_W      = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [3:0]       req0_op_i,
    input  logic [31:0]      req0_a_i,
    input  logic [31:0]      req0_b_i,
    input  logic [TAG_W-1:0] req0_tag_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [3:0]       req1_op_i,
    input  logic [31:0]      req1_a_i,
    input  logic [31:0]      req1_b_i,
    input  logic [TAG_W-1:0] req1_tag_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [31:0]      res_data_o,
    output logic [TAG_W-1:0] res_tag_o,
    output logic             res_src_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic        rr_q;
    logic        can_load;
    logic        grant1;
    logic        xfer;
    logic        stall;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_p;

    // Grant is decided from the valids alone so ready never looks at the loser's payload
    always_comb begin
        can_load = !res_valid_o || res_ready_i;
        if (req0_valid_i && req1_valid_i)
            grant1 = (FIXED_PRIO != 0) ? 1'b0 : rr_q;
        else
            grant1 = req1_valid_i;
        req0_ready_o = can_load && !grant1;
        req1_ready_o = can_load && grant1;
        xfer  = can_load && (req0_valid_i || req1_valid_i);
        stall = (req0_valid_i && !req0_ready_o) || (req1_valid_i && !req1_ready_o);
        alu_op = grant1 ? req1_op_i : req0_op_i;
        alu_a  = grant1 ? req1_a_i  : req0_a_i;
        alu_b  = grant1 ? req1_b_i  : req0_b_i;
    end

    riscv_alu u_alu (
        .alu_op_i (alu_op),
        .alu_a_i  (alu_a),
        .alu_b_i  (alu_b),
        .alu_p_o  (alu_p)
    );

    // A transfer overrides a pop, so pop+load replaces the entry without a bubble
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
            res_tag_o   <= '0;
            res_src_o   <= 1'b0;
            rr_q        <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            if (xfer) begin
                res_valid_o <= 1'b1;
                res_data_o  <= alu_p;
                res_tag_o   <= grant1 ? req1_tag_i : req0_tag_i;
                res_src_o   <= grant1;
                rr_q        <= ~grant1;
            end else if (res_ready_i) begin
                res_valid_o <= 1'b0;
            end
            if (stall && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_riscv_alu_share_arb.sv
// Drives a round-robin instance and a fixed-priority 4-bit-counter instance with the same
// stimulus and checks both against a cycle-level model plus hand-computed literals.

module tb_riscv_alu_share_arb;
    localparam int TAG_W = 5;
    localparam logic [3:0] OP_NONE = 4'd0, OP_SHL = 4'd1, OP_SHR = 4'd2, OP_SRA = 4'd3,
                           OP_ADD = 4'd4, OP_SUB = 4'd6, OP_AND = 4'd7, OP_OR = 4'd8,
                           OP_XOR = 4'd9, OP_SLTU = 4'd10, OP_SLT = 4'd11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v0 = 1'b0, v1 = 1'b0, res_ready = 1'b0;
    logic [3:0] op0 = '0, op1 = '0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [TAG_W-1:0] tag0 = '0, tag1 = '0;

    logic rdy0_rr, rdy1_rr, val_rr, src_rr;
    logic [31:0] data_rr;
    logic [TAG_W-1:0] tag_rr;
    logic [15:0] cnt_rr;
    logic rdy0_fx, rdy1_fx, val_fx, src_fx;
    logic [31:0] data_fx;
    logic [TAG_W-1:0] tag_fx;
    logic [3:0] cnt_fx;

    int n_compared = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    riscv_alu_share_arb #(.TAG_W(TAG_W), .CNT_W(16), .FIXED_PRIO(0)) dut_rr (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v0), .req0_ready_o(rdy0_rr), .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0), .req0_tag_i(tag0),
        .req1_valid_i(v1), .req1_ready_o(rdy1_rr), .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1), .req1_tag_i(tag1),
        .res_valid_o(val_rr), .res_ready_i(res_ready), .res_data_o(data_rr), .res_tag_o(tag_rr),
        .res_src_o(src_rr), .stall_cnt_o(cnt_rr)
    );

    riscv_alu_share_arb #(.TAG_W(TAG_W), .CNT_W(4), .FIXED_PRIO(1)) dut_fx (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v0), .req0_ready_o(rdy0_fx), .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0), .req0_tag_i(tag0),
        .req1_valid_i(v1), .req1_ready_o(rdy1_fx), .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1), .req1_tag_i(tag1),
        .res_valid_o(val_fx), .res_ready_i(res_ready), .res_data_o(data_fx), .res_tag_o(tag_fx),
        .res_src_o(src_fx), .stall_cnt_o(cnt_fx)
    );

    // Model state, index 0 = round-robin instance, index 1 = fixed-priority instance
    bit          m_valid [2];
    logic [31:0] m_data  [2];
    int          m_tag   [2];
    bit          m_src   [2];
    bit          m_rr    [2];
    int          m_cnt   [2];
    int          cnt_max [2] = '{65535, 15};
    bit          fixed   [2] = '{1'b0, 1'b1};
    bit          model_live = 1'b0;
    bit          acc0, acc1;

    function automatic logic [31:0] alu_model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            OP_SHL:  return a << b[4:0];
            OP_SHR:  return a >> b[4:0];
            OP_SRA:  return 32'($signed(a) >>> b[4:0]);
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a;
        endcase
    endfunction

    function automatic bit winner(int k);
        if (v0 && v1) return fixed[k] ? 1'b0 : m_rr[k];
        return v1;
    endfunction

    function automatic bit exp_ready(int k, bit lane);
        return (!m_valid[k] || res_ready) && (winner(k) == lane);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_valid[k] = 0; m_data[k] = '0; m_tag[k] = 0; m_src[k] = 0; m_rr[k] = 0; m_cnt[k] = 0;
            end else begin
                acc0 = v0 && exp_ready(k, 1'b0);
                acc1 = v1 && exp_ready(k, 1'b1);
                if (((v0 && !acc0) || (v1 && !acc1)) && m_cnt[k] < cnt_max[k])
                    m_cnt[k] = m_cnt[k] + 1;
                if (acc0 || acc1) begin
                    m_valid[k] = 1;
                    m_data[k]  = acc1 ? alu_model(op1, a1, b1) : alu_model(op0, a0, b0);
                    m_tag[k]   = acc1 ? int'(tag1) : int'(tag0);
                    m_src[k]   = acc1;
                    m_rr[k]    = !acc1;
                end else if (res_ready) begin
                    m_valid[k] = 0;
                end
            end
        end
        if (rst) model_live = 1'b1;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        check("rr valid", 32'(val_rr), 32'(m_valid[0]));
        check("rr data",  data_rr,     m_data[0]);
        check("rr tag",   32'(tag_rr), m_tag[0]);
        check("rr src",   32'(src_rr), 32'(m_src[0]));
        check("rr cnt",   32'(cnt_rr), m_cnt[0]);
        check("rr rdy0",  32'(rdy0_rr), 32'(exp_ready(0, 1'b0)));
        check("rr rdy1",  32'(rdy1_rr), 32'(exp_ready(0, 1'b1)));
        check("fx valid", 32'(val_fx), 32'(m_valid[1]));
        check("fx data",  data_fx,     m_data[1]);
        check("fx tag",   32'(tag_fx), m_tag[1]);
        check("fx src",   32'(src_fx), 32'(m_src[1]));
        check("fx cnt",   32'(cnt_fx), m_cnt[1]);
        check("fx rdy0",  32'(rdy0_fx), 32'(exp_ready(1, 1'b0)));
        check("fx rdy1",  32'(rdy1_fx), 32'(exp_ready(1, 1'b1)));
    endtask

    always @(negedge clk) if (model_live) checkOutput();

    task automatic applyStimulus(
        input logic r,
        input logic iv0, input logic [3:0] iop0, input logic [31:0] ia0, input logic [31:0] ib0, input int it0,
        input logic iv1, input logic [3:0] iop1, input logic [31:0] ia1, input logic [31:0] ib1, input int it1,
        input logic rr);
        rst = r;
        v0 = iv0; op0 = iop0; a0 = ia0; b0 = ib0; tag0 = TAG_W'(it0);
        v1 = iv1; op1 = iop1; a1 = ia1; b1 = ib1; tag1 = TAG_W'(it1);
        res_ready = rr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9] = '{
        '{OP_SHL,  32'h1,        32'h4,  32'h10},
        '{OP_SHR,  32'h80000000, 32'h4,  32'h08000000},
        '{OP_AND,  32'hF0F0,     32'hFF00, 32'hF000},
        '{OP_OR,   32'hF0,       32'h0F, 32'hFF},
        '{OP_SLTU, 32'hFFFFFFFF, 32'h1,  32'h0},
        '{OP_SLT,  32'hFFFFFFFF, 32'h1,  32'h1},
        '{4'd5,    32'h1234,     32'h99, 32'h1234},
        '{OP_NONE, 32'hABCD,     32'h11, 32'hABCD},
        '{OP_ADD,  32'hFFFFFFFF, 32'h1,  32'h0}
    };

    initial begin
        // Reset with both lanes requesting
        applyStimulus(1, 1, OP_ADD, 7, 5, 3, 1, OP_XOR, 32'hF0, 32'h0F, 2, 1);
        tick(); tick();
        check("lit reset valid rr", 32'(val_rr), 0);
        check("lit reset cnt rr", 32'(cnt_rr), 0);
        check("lit reset valid fx", 32'(val_fx), 0);

        applyStimulus(0, 1, OP_ADD, 7, 5, 3, 1, OP_XOR, 32'hF0, 32'h0F, 2, 1);
        check("lit first ready0", 32'(rdy0_rr), 1);
        check("lit first ready1", 32'(rdy1_rr), 0);
        tick();
        check("lit add data", data_rr, 12);
        check("lit add tag", 32'(tag_rr), 3);
        check("lit add src", 32'(src_rr), 0);
        check("lit add valid", 32'(val_rr), 1);

        // Contended lanes: round-robin alternates, fixed priority always lane 0
        applyStimulus(0, 1, OP_SUB, 10, 3, 1, 1, OP_XOR, 32'hF0, 32'h0F, 2, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("lit rr alt data", data_rr, (i % 2 == 0) ? 32'hFF : 32'd7);
            check("lit rr alt src", 32'(src_rr), (i % 2 == 0) ? 1 : 0);
            check("lit rr cnt", 32'(cnt_rr), 2 + i);
            check("lit fx data", data_fx, 7);
            check("lit fx src", 32'(src_fx), 0);
        end

        // Back-pressure holds the result, then pop and reload on one edge
        applyStimulus(0, 1, OP_SUB, 10, 3, 1, 1, OP_XOR, 32'hF0, 32'h0F, 2, 0);
        check("lit bp ready0", 32'(rdy0_rr), 0);
        check("lit bp ready1", 32'(rdy1_rr), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lit bp held data", data_rr, 7);
            check("lit bp cnt", 32'(cnt_rr), 6 + i);
        end
        applyStimulus(0, 1, OP_SUB, 10, 3, 1, 1, OP_XOR, 32'hF0, 32'h0F, 2, 1);
        check("lit release ready1", 32'(rdy1_rr), 1);
        tick();
        check("lit reload data", data_rr, 32'hFF);
        check("lit reload src", 32'(src_rr), 1);
        check("lit reload cnt", 32'(cnt_rr), 9);
        check("lit fx reload cnt", 32'(cnt_fx), 9);

        // Long stall saturates the narrow counter
        applyStimulus(0, 1, OP_SUB, 10, 3, 1, 1, OP_XOR, 32'hF0, 32'h0F, 2, 0);
        for (int i = 0; i < 20; i++) tick();
        check("lit fx saturated", 32'(cnt_fx), 15);
        check("lit rr long cnt", 32'(cnt_rr), 29);

        applyStimulus(0, 0, OP_NONE, 0, 0, 0, 1, OP_SRA, 32'h80000000, 4, 7, 1);
        tick();
        check("lit sra rr", data_rr, 32'hF8000000);
        check("lit sra fx", data_fx, 32'hF8000000);
        check("lit sra src", 32'(src_fx), 1);
        check("lit sra tag", 32'(tag_fx), 7);
        check("lit fx still sat", 32'(cnt_fx), 15);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 1, vecs[i].op, vecs[i].a, vecs[i].b, i, 0, OP_NONE, 0, 0, 0, 1);
            tick();
            check("lit alu vec", data_rr, vecs[i].exp);
        end

        applyStimulus(0, 0, OP_NONE, 0, 0, 0, 0, OP_NONE, 0, 0, 0, 1);
        tick();
        check("lit drained", 32'(val_rr), 0);

        // Reset discards an entry even when the consumer is ready
        applyStimulus(0, 1, OP_ADD, 1, 2, 4, 0, OP_NONE, 0, 0, 0, 0);
        tick();
        check("lit pre-reset valid", 32'(val_rr), 1);
        applyStimulus(1, 1, OP_ADD, 1, 2, 4, 1, OP_ADD, 3, 4, 5, 1);
        tick();
        check("lit reset discard", 32'(val_rr), 0);
        check("lit reset cnt", 32'(cnt_fx), 0);
        applyStimulus(0, 0, OP_NONE, 0, 0, 0, 0, OP_NONE, 0, 0, 0, 1);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
